// File: rtl/te_event_fifo_pkg.sv
// -----------------------------------------------------------------------------
// te_event_fifo_pkg
// Shared definitions for the TE event FIFO: register addresses, source codes,
// control/status bit positions and a small watermark helper.
// No ports (package).
// -----------------------------------------------------------------------------
package te_event_fifo_pkg;

    // Register map (DWORD addresses)
    localparam logic [5:0] TEF_CTRL   = 6'h00;
    localparam logic [5:0] TEF_STATUS = 6'h01;
    localparam logic [5:0] TEF_DATA   = 6'h02;
    localparam logic [5:0] TEF_THRESH = 6'h03;

    // Source codes carried in the top bits of each queued entry
    localparam logic [1:0] SRC_PPS = 2'd0;
    localparam logic [1:0] SRC_EM  = 2'd1;

    // Control / status bit positions
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;
    localparam int CTRL_SRC_EN_LSB = 8;
    localparam int STATUS_OVF_BIT  = 31;
    localparam int STATUS_PEND_LSB = 16;

    // A programmed watermark of zero behaves like a watermark of one
    function automatic logic [6:0] eff_thresh(input logic [6:0] thresh);
        if (thresh == 7'd0) begin
            eff_thresh = 7'd1;
        end else begin
            eff_thresh = thresh;
        end
    endfunction

endpackage

// File: rtl/te_event_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// te_event_fifo_sync_fifo
// Single-clock DEPTH x WIDTH register-array FIFO with synchronous flush.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, pop        enqueue / dequeue requests (pop ignored when empty,
//                    push ignored when full unless a pop happens the same cycle)
//   flush            clears pointers and count; overrides push/pop
//   wdata            entry to enqueue
//   full, empty      occupancy flags
//   count            occupancy, 0..DEPTH
//   head             entry at the read pointer
// -----------------------------------------------------------------------------
module te_event_fifo_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_pop_s;
    logic              do_push_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    // A pop frees the slot the same cycle, so a full FIFO still accepts a push
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array: data only, validity is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/te_event_fifo.sv
// -----------------------------------------------------------------------------
// te_event_fifo
// Records PPS / external events into the TE FIFO. Each asynchronous event
// level is synchronized, rising edges capture te_time, and a fixed-priority
// arbiter queues {src, timestamp} entries that the host pops over the DWORD
// register bus.
// Optional macro TEF_WATERMARK_IRQ_EN: adds the TEF_THRESH watermark register
// and raises tef_irq when count >= watermark instead of count != 0.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   host_cs/rd/wr register select and one-cycle read/write strobes
//   host_addr     DWORD register address
//   host_d4wt     write data
//   host_d4rd     read data, combinational on host_addr
//   event_in      async event levels, bit 0 = pps_event
//   te_time       TE time count (clk domain)
//   tef_irq       registered level interrupt
// -----------------------------------------------------------------------------
module te_event_fifo
    import te_event_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 30,
    parameter int NUM_SRC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_cs,
    input  logic                host_rd,
    input  logic                host_wr,
    input  logic [5:0]          host_addr,
    input  logic [31:0]         host_d4wt,
    output logic [31:0]         host_d4rd,
    input  logic [NUM_SRC-1:0]  event_in,
    input  logic [TS_WIDTH-1:0] te_time,
    output logic                tef_irq
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 2 + TS_WIDTH;

    logic [NUM_SRC-1:0]  sync1_r;
    logic [NUM_SRC-1:0]  sync2_r;
    logic [NUM_SRC-1:0]  sync3_r;
    logic [NUM_SRC-1:0]  detect_s;
    logic [NUM_SRC-1:0]  cap_s;
    logic [NUM_SRC-1:0]  pending_r;
    logic [TS_WIDTH-1:0] cap_ts_r [NUM_SRC];
    logic [NUM_SRC-1:0]  src_enable_r;
    logic                irq_enable_r;
    logic                overflow_r;
    logic                irq_r;
    logic                irq_cond_s;

    logic [NUM_SRC-1:0]  grant_s;
    logic [1:0]          grant_idx_s;
    logic [TS_WIDTH-1:0] grant_ts_s;
    logic                push_s;
    logic                pop_s;
    logic                pop_ok_s;
    logic                flush_s;
    logic                wr_en_s;
    logic                ovf_set_s;
    logic                ovf_clr_s;
    logic                full_s;
    logic                empty_s;
    logic [CNT_W-1:0]    count_s;
    logic [6:0]          count7_s;
    logic [ENTRY_W-1:0]  head_s;
    logic [31:0]         rd_data_s;
    logic                unused_wdata_s;

`ifdef TEF_WATERMARK_IRQ_EN
    logic [6:0]          thresh_r;
`endif

    assign detect_s  = sync2_r & ~sync3_r;
    assign cap_s     = detect_s & src_enable_r;
    assign wr_en_s   = host_cs & host_wr;
    assign flush_s   = wr_en_s & (host_addr == TEF_CTRL) & host_d4wt[CTRL_FLUSH_BIT];
    assign pop_s     = host_cs & host_rd & (host_addr == TEF_DATA);
    assign pop_ok_s  = pop_s & ~empty_s;
    assign push_s    = |pending_r;
    assign count7_s  = 7'(count_s);
    assign ovf_clr_s = wr_en_s & (host_addr == TEF_STATUS) & host_d4wt[STATUS_OVF_BIT];
    // Overflow sources: a push dropped on a full FIFO, or a source re-firing
    // before its previous capture was queued
    assign ovf_set_s = (push_s & full_s & ~pop_ok_s & ~flush_s) | (|(cap_s & pending_r));
    assign host_d4rd = rd_data_s;
    assign tef_irq   = irq_r;
    assign unused_wdata_s = ^host_d4wt;

    // Two-flop synchronizer plus one delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {NUM_SRC{1'b0}};
            sync2_r <= {NUM_SRC{1'b0}};
            sync3_r <= {NUM_SRC{1'b0}};
        end else begin
            sync1_r <= event_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Fixed-priority arbiter: the lowest-index pending source wins
    always_comb begin
        grant_s     = {NUM_SRC{1'b0}};
        grant_idx_s = 2'd0;
        grant_ts_s  = {TS_WIDTH{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                grant_s     = {NUM_SRC{1'b0}};
                grant_s[i]  = 1'b1;
                grant_idx_s = 2'(i);
                grant_ts_s  = cap_ts_r[i];
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    // Per-source capture of te_time and pending tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NUM_SRC{1'b0}};
            for (int i = 0; i < NUM_SRC; i++) begin
                cap_ts_r[i] <= {TS_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                // Flush beats a new capture so nothing survives a flush
                if (flush_s) begin
                    pending_r[i] <= 1'b0;
                end else if (cap_s[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (grant_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
                if (cap_s[i]) begin
                    cap_ts_r[i] <= te_time;
                end
            end
        end
    end

    // Sticky overflow; a new overflow event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Control register (flush bit is a strobe and is not stored)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_enable_r <= {NUM_SRC{1'b0}};
            irq_enable_r <= 1'b0;
        end else if (wr_en_s && host_addr == TEF_CTRL) begin
            src_enable_r <= host_d4wt[CTRL_SRC_EN_LSB +: NUM_SRC];
            irq_enable_r <= host_d4wt[CTRL_IRQ_EN_BIT];
        end else begin
            src_enable_r <= src_enable_r;
            irq_enable_r <= irq_enable_r;
        end
    end

`ifdef TEF_WATERMARK_IRQ_EN
    // Watermark register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_r <= 7'd1;
        end else if (wr_en_s && host_addr == TEF_THRESH) begin
            thresh_r <= host_d4wt[6:0];
        end else begin
            thresh_r <= thresh_r;
        end
    end

    assign irq_cond_s = (count7_s >= eff_thresh(thresh_r)) | overflow_r;
`else
    assign irq_cond_s = (count7_s != 7'd0) | overflow_r;
`endif

    // Interrupt is registered, so it follows count with one cycle of lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_enable_r & irq_cond_s;
        end
    end

    // Register read mux; the data port shows the head while it is popped
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (host_addr)
            TEF_CTRL: begin
                rd_data_s[CTRL_SRC_EN_LSB +: NUM_SRC] = src_enable_r;
                rd_data_s[CTRL_IRQ_EN_BIT]            = irq_enable_r;
            end
            TEF_STATUS: begin
                rd_data_s[STATUS_OVF_BIT]              = overflow_r;
                rd_data_s[STATUS_PEND_LSB +: NUM_SRC]  = pending_r;
                rd_data_s[6:0]                         = count7_s;
            end
            TEF_DATA: begin
                if (!empty_s) begin
                    rd_data_s[ENTRY_W-1:0] = head_s;
                end else begin
                    rd_data_s = 32'h0000_0000;
                end
            end
`ifdef TEF_WATERMARK_IRQ_EN
            TEF_THRESH: begin
                rd_data_s[6:0] = thresh_r;
            end
`endif
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
    end

    te_event_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata ({grant_idx_s, grant_ts_s}),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s),
        .head  (head_s)
    );

endmodule

// File: tb/tb_te_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_te_event_fifo
// Self-checking bench for te_event_fifo. A queue-based reference model holds
// the expected FIFO contents, overflow flag and interrupt state.
// -----------------------------------------------------------------------------
module tb_te_event_fifo;
    import te_event_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_cs;
    logic        host_rd;
    logic        host_wr;
    logic [5:0]  host_addr;
    logic [31:0] host_d4wt;
    logic [31:0] host_d4rd;
    logic [1:0]  event_in;
    logic [29:0] te_time;
    logic        tef_irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    logic [31:0] q_m [$];
    bit          ovf_m;
    bit [1:0]    en_m;
    bit          irq_en_m;
    int          thresh_m;

    te_event_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .host_cs   (host_cs),
        .host_rd   (host_rd),
        .host_wr   (host_wr),
        .host_addr (host_addr),
        .host_d4wt (host_d4wt),
        .host_d4rd (host_d4rd),
        .event_in  (event_in),
        .te_time   (te_time),
        .tef_irq   (tef_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [31:0] d);
        host_cs = 1'b1; host_wr = 1'b1; host_addr = a; host_d4wt = d;
        tick();
        host_cs = 1'b0; host_wr = 1'b0; host_d4wt = 32'h0;
    endtask

    task automatic host_read(input logic [5:0] a, output logic [31:0] d);
        host_cs = 1'b1; host_rd = 1'b1; host_addr = a;
        #1 d = host_d4rd;
        tick();
        host_cs = 1'b0; host_rd = 1'b0;
    endtask

    task automatic peek(input logic [5:0] a, output logic [31:0] d);
        host_addr = a;
        #1 d = host_d4rd;
    endtask

    function automatic bit exp_irq();
`ifdef TEF_WATERMARK_IRQ_EN
        int t;
        t = (thresh_m == 0) ? 1 : thresh_m;
        return irq_en_m && ((q_m.size() >= t) || ovf_m);
`else
        return irq_en_m && ((q_m.size() != 0) || ovf_m);
`endif
    endfunction

    function automatic void model_push(input logic [31:0] e);
        if (q_m.size() < DEPTH) q_m.push_back(e);
        else ovf_m = 1'b1;
    endfunction

    function automatic void model_reset();
        q_m.delete();
        ovf_m = 1'b0; en_m = 2'b00; irq_en_m = 1'b0; thresh_m = 1;
    endfunction

    task automatic set_ctrl(input bit [1:0] en, input bit ie);
        en_m = en; irq_en_m = ie;
        host_write(TEF_CTRL, {22'h0, en, 6'h0, ie, 1'b0});
    endtask

    // Raise the given sources together with te_time held steady across detection
    task automatic fire(input logic [1:0] mask, input logic [29:0] ts);
        te_time  = ts;
        event_in = mask;
        repeat (4) tick();
        te_time  = 30'($urandom);
        event_in = 2'b00;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            if (mask[i] && en_m[i]) model_push({2'(i), ts});
        end
    endtask

    // Status register (pending expected clear) and interrupt vs. the model
    task automatic chk_status(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        tick();
        peek(TEF_STATUS, d);
        e = 32'h0;
        e[31]  = ovf_m;
        e[6:0] = 7'(q_m.size());
        check_val({tag, "_status"}, d, e);
        check_val({tag, "_irq"}, {31'h0, tef_irq}, {31'h0, exp_irq()});
    endtask

    task automatic pop_expect(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (q_m.size() != 0) ? q_m.pop_front() : 32'h0;
        host_read(TEF_DATA, d);
        check_val(tag, d, e);
    endtask

    initial begin
        logic [31:0] d;
        logic [29:0] ts;
        rst = 1'b1; host_cs = 1'b0; host_rd = 1'b0; host_wr = 1'b0;
        host_addr = 6'h0; host_d4wt = 32'h0; event_in = 2'b00; te_time = 30'h0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        peek(TEF_CTRL, d);   check_val("rst_ctrl", d, 32'h0);
        peek(TEF_STATUS, d); check_val("rst_status", d, 32'h0);
        peek(TEF_DATA, d);   check_val("rst_data", d, 32'h0);
        peek(6'h3F, d);      check_val("undef_addr", d, 32'h0);
        check_val("rst_irq", {31'h0, tef_irq}, 32'h0);

        // 1: single PPS event, pop, irq rises and falls
        set_ctrl(2'b01, 1'b1);
        peek(TEF_CTRL, d); check_val("ctrl_rb", d, 32'h0000_0102);
        fire(2'b01, 30'h123);
        chk_status("t1_one");
        pop_expect("t1_data");
        check_val("t1_data_val", d, d);
        chk_status("t1_empty");
        pop_expect("t1_empty_read");
        chk_status("t1_still_empty");

        // 2: simultaneous edges, cycle-exact pending drain and ordering
        set_ctrl(2'b11, 1'b1);
        te_time = 30'd100; event_in = 2'b11;
        repeat (3) tick();
        peek(TEF_STATUS, d); check_val("t2_pend_both", d, 32'h0003_0000);
        tick();
        peek(TEF_STATUS, d); check_val("t2_pend_src1", d, 32'h0002_0001);
        tick();
        peek(TEF_STATUS, d); check_val("t2_pend_none", d, 32'h0000_0002);
        event_in = 2'b00;
        repeat (4) tick();
        q_m.push_back({SRC_PPS, 30'd100});
        q_m.push_back({SRC_EM, 30'd100});
        pop_expect("t2_first");
        pop_expect("t2_second");
        chk_status("t2_done");

        // disabled source is ignored
        set_ctrl(2'b01, 1'b0);
        fire(2'b10, 30'h55);
        chk_status("dis_src");

        // 3: 17 events into a 16-deep FIFO
        for (int i = 0; i < 17; i++) fire(2'b01, 30'(1000 + i));
        chk_status("t3_full");
        host_write(TEF_STATUS, 32'h8000_0000);
        ovf_m = 1'b0;
        chk_status("t3_w1c");

        // 4: pop coincides with push on a full FIFO
        te_time = 30'h3ABC; event_in = 2'b01;
        repeat (3) tick();
        host_cs = 1'b1; host_rd = 1'b1; host_addr = TEF_DATA;
        #1 check_val("t4_head", host_d4rd, q_m[0]);
        tick();
        host_cs = 1'b0; host_rd = 1'b0;
        void'(q_m.pop_front());
        q_m.push_back({SRC_PPS, 30'h3ABC});
        event_in = 2'b00;
        repeat (4) tick();
        chk_status("t4_count16");
        for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("t4_drain%0d", i));
        chk_status("t4_empty");

        // 5: flush after 5 entries, then reset during a push
        set_ctrl(2'b01, 1'b1);
        for (int i = 0; i < 5; i++) fire(2'b01, 30'(2000 + i));
        chk_status("t5_five");
        host_write(TEF_CTRL, 32'h0000_0106);
        q_m.delete();
        tick();
        peek(TEF_DATA, d); check_val("t5_flush_data", d, 32'h0);
        chk_status("t5_flushed");
        te_time = 30'h777; event_in = 2'b01;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        event_in = 2'b00;
        model_reset();
        repeat (4) tick();
        peek(TEF_CTRL, d); check_val("t5_rst_ctrl", d, 32'h0);
        peek(TEF_DATA, d); check_val("t5_rst_data", d, 32'h0);
        chk_status("t5_rst");

        // 6: watermark interrupt, or THRESH absent in the default build
`ifdef TEF_WATERMARK_IRQ_EN
        peek(TEF_THRESH, d); check_val("t6_thresh_rst", d, 32'h1);
        host_write(TEF_THRESH, 32'h4);
        thresh_m = 4;
        set_ctrl(2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fire(2'b01, 30'(3000 + i));
            chk_status($sformatf("t6_below%0d", i));
        end
        fire(2'b01, 30'd3003);
        chk_status("t6_at");
        pop_expect("t6_pop");
        chk_status("t6_after_pop");
        host_write(TEF_THRESH, 32'h0);
        thresh_m = 0;
        chk_status("t6_thresh0");
        while (q_m.size() != 0) pop_expect("t6_drain");
`else
        host_write(TEF_THRESH, 32'h0000_007F);
        peek(TEF_THRESH, d); check_val("t6_thresh_absent", d, 32'h0);
`endif

        // randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) set_ctrl(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            ts = 30'($urandom);
            fire(2'($urandom_range(1, 3)), ts);
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_expect($sformatf("rnd%0d_pop", r));
            if ($urandom_range(0, 4) == 0) begin
                host_write(TEF_STATUS, 32'h8000_0000);
                ovf_m = 1'b0;
            end
            chk_status($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
